// File: rtl/memory_island_pkg.sv
// Shared types for the memory island core.
package memory_island_pkg;

   // Arbitration priority of one bank group: narrow requesters by default,
   // wide requester after it has been starved long enough.
   typedef enum logic [0:0] {
      NARROW_PRIO = 1'b0,
      WIDE_PRIO   = 1'b1
   } bank_arb_state_e;

endpackage

// File: rtl/mem_rsp_tag_pipe.sv
// Valid-bit delay line: Depth registered stages of Width bits, async clear.
// Tags each granted read so its response strobe lines up with the bank data.
module mem_rsp_tag_pipe #(
   parameter int unsigned Width = 1,
   parameter int unsigned Depth = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] vld_i,
   output logic [Width-1:0] vld_o
);

   logic [Width-1:0] vld_pipe [Depth];

   for (genvar s = 0; s < Depth; s++) begin : g_stage
      if (s == 0) begin : g_first
         // First stage captures this cycle's tags; reset drops in-flight reads.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) vld_pipe[s] <= '0;
            else         vld_pipe[s] <= vld_i;
         end
      end else begin : g_next
         // Later stages just shift the tags along.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) vld_pipe[s] <= '0;
            else         vld_pipe[s] <= vld_pipe[s-1];
         end
      end
   end

   assign vld_o = vld_pipe[Depth-1];

endmodule

// File: rtl/mem_bank_group_arbiter.sv
// Arbitrates one group of narrow banks between per-bank narrow requests and
// a wide request spanning the group. Narrow wins by default; a wide request
// blocked MaxWideStall consecutive cycles gets the group for one grant.
module mem_bank_group_arbiter
   import memory_island_pkg::*;
#(
   parameter int unsigned NarrowPerWide = 4,
   parameter int unsigned BankLatency   = 1,
   parameter int unsigned MaxWideStall  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NarrowPerWide-1:0] narrow_req_i,
   input  logic [NarrowPerWide-1:0] narrow_we_i,
   output logic [NarrowPerWide-1:0] narrow_gnt_o,
   input  logic                     wide_req_i,
   input  logic                     wide_we_i,
   output logic                     wide_gnt_o,
   output logic [NarrowPerWide-1:0] bank_en_o,
   output logic                     bank_sel_wide_o,
   output logic [NarrowPerWide-1:0] narrow_rvalid_o,
   output logic                     wide_rvalid_o
);

   localparam int unsigned      CntW   = $clog2(MaxWideStall + 1);
   localparam logic [CntW-1:0]  CntMax = CntW'(MaxWideStall);

   bank_arb_state_e              state_q;
   logic [CntW-1:0]              cnt_q;
   logic [CntW-1:0]              cnt_inc;
   logic [NarrowPerWide-1:0]     narrow_gnt;
   logic                         wide_gnt;
   logic                         wide_blocked;

   // Grants are purely combinational from requests and the priority state.
   always_comb begin
      narrow_gnt = '0;
      wide_gnt   = 1'b0;
      if (state_q == WIDE_PRIO) begin
         wide_gnt = wide_req_i;
      end else begin
         narrow_gnt = narrow_req_i;
         wide_gnt   = wide_req_i & ~|narrow_req_i;
      end
   end

   assign wide_blocked    = wide_req_i & ~wide_gnt;
   assign cnt_inc         = (cnt_q == CntMax) ? CntMax : cnt_q + CntW'(1);

   assign narrow_gnt_o    = narrow_gnt;
   assign wide_gnt_o      = wide_gnt;
   assign bank_sel_wide_o = wide_gnt;
   assign bank_en_o       = wide_gnt ? {NarrowPerWide{1'b1}} : narrow_gnt;

   // Priority FSM and starvation counter. In WIDE_PRIO the wide request is
   // either granted or withdrawn, so that state always lasts one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= NARROW_PRIO;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            NARROW_PRIO: begin
               if (wide_blocked) begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == CntMax) state_q <= WIDE_PRIO;
               end else begin
                  cnt_q <= '0;
               end
            end
            WIDE_PRIO: begin
               state_q <= NARROW_PRIO;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= NARROW_PRIO;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Read tags travel with the bank access; writes carry no tag.
   mem_rsp_tag_pipe #(
      .Width (NarrowPerWide + 1),
      .Depth (BankLatency)
   ) i_rsp_tag_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .vld_i  ({narrow_gnt & ~narrow_we_i, wide_gnt & ~wide_we_i}),
      .vld_o  ({narrow_rvalid_o, wide_rvalid_o})
   );

endmodule

// File: tb/tb_mem_bank_group_arbiter.sv
// Bench for mem_bank_group_arbiter: table vectors, hand sequences for the
// starvation / withdrawal / reset corners, and randomized traffic checked
// against a rule-level reference model.
module tb_mem_bank_group_arbiter;

   localparam int N   = 4;
   localparam int BL  = 2;
   localparam int MWS = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] narrow_req = '0, narrow_we = '0;
   logic         wide_req = 1'b0, wide_we = 1'b0;
   logic [N-1:0] narrow_gnt, bank_en, narrow_rvalid;
   logic         wide_gnt, bank_sel, wide_rvalid;

   int checks = 0;
   int failures = 0;

   // reference model state
   int           blocked_run;
   logic [N:0]   hist[$];

   always #5 clk = ~clk;

   mem_bank_group_arbiter #(
      .NarrowPerWide (N),
      .BankLatency   (BL),
      .MaxWideStall  (MWS)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .narrow_req_i    (narrow_req),
      .narrow_we_i     (narrow_we),
      .narrow_gnt_o    (narrow_gnt),
      .wide_req_i      (wide_req),
      .wide_we_i       (wide_we),
      .wide_gnt_o      (wide_gnt),
      .bank_en_o       (bank_en),
      .bank_sel_wide_o (bank_sel),
      .narrow_rvalid_o (narrow_rvalid),
      .wide_rvalid_o   (wide_rvalid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      blocked_run = 0;
      hist = {};
      for (int i = 0; i < BL; i++) hist.push_back('0);
   endtask

   // One clock cycle: drive inputs, sample at negedge, compare with the
   // model, advance the model, return just after the next rising edge.
   task automatic cycle(input logic [N-1:0] nreq, input logic [N-1:0] nwe,
                        input logic wreq, input logic wwe,
                        output logic [N-1:0] s_ngnt, output logic s_wgnt,
                        output logic [N-1:0] s_en, output logic s_sel);
      logic         prio, e_wg, e_sel;
      logic [N-1:0] e_ng, e_en;
      logic [N:0]   e_rv;
      narrow_req = nreq; narrow_we = nwe; wide_req = wreq; wide_we = wwe;
      @(negedge clk);
      prio  = (blocked_run >= MWS);
      e_wg  = wreq && (prio || nreq == '0);
      e_ng  = prio ? '0 : nreq;
      e_en  = e_wg ? {N{1'b1}} : e_ng;
      e_sel = e_wg;
      e_rv  = hist.pop_front();
      hist.push_back({e_ng & ~nwe, e_wg & ~wwe});
      chk("narrow_gnt", 32'(narrow_gnt), 32'(e_ng));
      chk("wide_gnt", 32'(wide_gnt), 32'(e_wg));
      chk("bank_en", 32'(bank_en), 32'(e_en));
      chk("bank_sel", 32'(bank_sel), 32'(e_sel));
      chk("narrow_rvalid", 32'(narrow_rvalid), 32'(e_rv[N:1]));
      chk("wide_rvalid", 32'(wide_rvalid), 32'(e_rv[0]));
      s_ngnt = narrow_gnt; s_wgnt = wide_gnt; s_en = bank_en; s_sel = bank_sel;
      if (wreq && !e_wg) blocked_run++;
      else               blocked_run = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic [N-1:0] a, c;
      logic b, d;
      for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0, a, b, c, d);
   endtask

   // Asynchronous reset pulse placed mid-cycle, away from the clock edges.
   task automatic pulse_reset();
      narrow_req = '0; narrow_we = '0; wide_req = 1'b0; wide_we = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_narrow_rvalid", 32'(narrow_rvalid), 32'h0);
      chk("rst_wide_rvalid", 32'(wide_rvalid), 32'h0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   typedef struct {
      logic [N-1:0] nreq, nwe;
      logic         wreq, wwe;
      logic [N-1:0] ngnt, en;
      logic         wgnt, sel;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [N-1:0] s_ngnt, s_en;
      logic         s_wgnt, s_sel;

      // reset held: every output is 0
      #3;
      chk("rst_narrow_gnt", 32'(narrow_gnt), 32'h0);
      chk("rst_wide_gnt", 32'(wide_gnt), 32'h0);
      chk("rst_bank_en", 32'(bank_en), 32'h0);
      chk("rst_rvalid", 32'({narrow_rvalid, wide_rvalid}), 32'h0);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      idle(2);

      // table vectors, each from NARROW_PRIO with a cleared counter
      vecs.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0});
      vecs.push_back('{4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b0101, 1'b0, 1'b0});
      vecs.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1});
      vecs.push_back('{4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0});
      vecs.push_back('{4'b1000, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0});
      vecs.push_back('{4'b1111, 4'b0110, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0});
      vecs.push_back('{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1});
      foreach (vecs[i]) begin
         cycle(vecs[i].nreq, vecs[i].nwe, vecs[i].wreq, vecs[i].wwe, s_ngnt, s_wgnt, s_en, s_sel);
         chk($sformatf("vec%0d_ngnt", i), 32'(s_ngnt), 32'(vecs[i].ngnt));
         chk($sformatf("vec%0d_wgnt", i), 32'(s_wgnt), 32'(vecs[i].wgnt));
         chk($sformatf("vec%0d_en", i), 32'(s_en), 32'(vecs[i].en));
         chk($sformatf("vec%0d_sel", i), 32'(s_sel), 32'(vecs[i].sel));
         idle(BL);
      end

      // starvation: narrow bank 0 + wide held -> wide granted every 5th cycle
      for (int i = 0; i < 3 * (MWS + 1); i++) begin
         cycle(4'b0001, 4'b0000, 1'b1, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
         chk("starve_wgnt", 32'(s_wgnt), 32'((i % (MWS + 1)) == MWS));
         chk("starve_ngnt", 32'(s_ngnt), ((i % (MWS + 1)) == MWS) ? 32'h0 : 32'h1);
      end
      idle(BL);

      // withdrawal in WIDE_PRIO: narrow blocked that cycle, granted the next
      for (int i = 0; i < MWS; i++) cycle(4'b0001, 4'b0000, 1'b1, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
      cycle(4'b0001, 4'b0000, 1'b0, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
      chk("wdraw_ngnt_wideprio", 32'(s_ngnt), 32'h0);
      cycle(4'b0001, 4'b0000, 1'b0, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
      chk("wdraw_ngnt_after", 32'(s_ngnt), 32'h1);
      // counter cleared: wide needs a full MWS blocked cycles again
      for (int i = 0; i <= MWS; i++) begin
         cycle(4'b0010, 4'b0000, 1'b1, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
         chk("wdraw_recount", 32'(s_wgnt), 32'(i == MWS));
      end
      idle(BL);

      // wide write then narrow read bank 3: only narrow_rvalid[3] pulses
      cycle(4'b0000, 4'b0000, 1'b1, 1'b1, s_ngnt, s_wgnt, s_en, s_sel);
      cycle(4'b1000, 4'b0000, 1'b0, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
      chk("mix_nrv_early", 32'(narrow_rvalid), 32'h0);
      cycle(4'b0000, 4'b0000, 1'b0, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
      chk("mix_nrv", 32'(narrow_rvalid), 32'h8);
      chk("mix_wrv", 32'(wide_rvalid), 32'h0);
      idle(BL);

      // reset while a read is in flight: its rvalid never appears
      cycle(4'b0101, 4'b0000, 1'b0, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
      pulse_reset();
      idle(BL + 1);
      // reset while wide is being starved: counter restarts from zero
      for (int i = 0; i < MWS - 1; i++) cycle(4'b0001, 4'b0000, 1'b1, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
      pulse_reset();
      for (int i = 0; i <= MWS; i++) cycle(4'b0001, 4'b0000, 1'b1, 1'b0, s_ngnt, s_wgnt, s_en, s_sel);
      idle(BL);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] nr;
         nr = N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
         cycle(nr, N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               s_ngnt, s_wgnt, s_en, s_sel);
      end
      idle(BL + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bank_group_arbiter.md
# mem_bank_group_arbiter

Per-bank-group access arbiter in the memory island core. It shares a group of NarrowPerWide adjacent narrow SRAM banks between per-bank narrow requests and one wide request spanning the whole group. It drives the bank-access multiplexer select and bank enables, enforces a bounded-starvation policy for wide accesses, and returns read-valid strobes to the winning requester after the bank access latency. There is one instance per wide bank, placed between the routed spill registers and the bank access multiplexer.

## Interface
- NarrowPerWide, default 4: narrow banks per group (WideDataWidth/NarrowDataWidth); ≥1.
- BankLatency, default 1: cycles from bank enable to read data valid, including bank multicut stages; ≥1.
- MaxWideStall, default 4: consecutive blocked cycles after which wide gets priority; ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- narrow_req_i  in  NarrowPerWide  per-bank narrow request (q_valid).
- narrow_we_i  in  NarrowPerWide  per-bank narrow write flag.
- narrow_gnt_o  out  NarrowPerWide  per-bank narrow grant (q_ready).
- wide_req_i  in  1  wide request (q_valid).
- wide_we_i  in  1  wide write flag.
- wide_gnt_o  out  1  wide grant (q_ready).
- bank_en_o  out  NarrowPerWide  bank request enable to the SRAMs.
- bank_sel_wide_o  out  1  mux select: 1 routes the wide split request to all banks of the group.
- narrow_rvalid_o  out  NarrowPerWide  narrow read data valid (p_valid).
- wide_rvalid_o  out  1  wide read data valid.

## Operation
- State machine: NARROW_PRIO (reset state) and WIDE_PRIO.
- NARROW_PRIO:
  - narrow_gnt_o = narrow_req_i.
  - wide_gnt_o = wide_req_i & ~|narrow_req_i.
- WIDE_PRIO:
  - narrow_gnt_o = 0.
  - wide_gnt_o = wide_req_i.
- bank_sel_wide_o = wide_gnt_o.
- bank_en_o = wide_gnt_o ? all-ones : narrow_gnt_o.
- The stall counter has width clog2(MaxWideStall+1).
  - It increments each cycle that wide_req_i=1 and wide_gnt_o=0.
  - It clears on a wide grant or when wide_req_i=0.
  - It saturates at MaxWideStall.
- Transitions:
  - NARROW_PRIO→WIDE_PRIO when a blocked cycle brings the counter to MaxWideStall.
  - WIDE_PRIO→NARROW_PRIO after a wide grant, or if wide_req_i drops (withdrawn request). The counter clears in both cases.
- Consequence: a narrow requester waits at most 1 cycle per wide grant. A wide requester waits at most MaxWideStall+1 cycles.
- Response tagging uses a BankLatency-deep delay line of {narrow read bits[NarrowPerWide], wide read bit}.
  - Stage-0 input is narrow_gnt_o & ~narrow_we_i, together with wide_gnt_o & ~wide_we_i.
  - The outputs of the last stage are narrow_rvalid_o and wide_rvalid_o.
  - Writes produce no rvalid.
- Narrow and wide rvalid are never asserted in the same cycle for the same bank.

## Timing
- Grants, bank_en_o and bank_sel_wide_o are combinational from requests and the registered state. There is no added request latency.
- rvalid is asserted exactly BankLatency cycles after the granting cycle, for one cycle per granted read. Back-to-back grants give back-to-back rvalids.
- The state and counter update on the rising edge. A new state takes effect for requests in the following cycle.
- Reset (asynchronous, at any time, including mid-access):
  - State goes to NARROW_PRIO, the counter to 0, and all delay-line stages to 0.
  - Hence narrow_rvalid_o=0 and wide_rvalid_o=0.
  - In-flight reads are dropped without rvalid.
- Combinational outputs are 0 whenever all requests are 0.
- Simultaneous narrow and wide requests in NARROW_PRIO: narrow wins, and the cycle counts as blocked for wide.
- A narrow request on any single bank blocks wide.

## Structure
- memory_island_pkg: add the enum bank_arb_state_e {NARROW_PRIO, WIDE_PRIO}.
- mem_bank_group_arbiter is instantiated per wide bank. It replaces the static mux-select condition with bank_sel_wide_o.
- Sub-module mem_rsp_tag_pipe is a parameterised-width, BankLatency-deep valid shift register with asynchronous clear. It is reusable for the other response paths.

## Test plan
- Reset, no requests, NarrowPerWide=4 → all outputs 0. A reset pulse during an in-flight read (BankLatency=2) → no rvalid afterwards.
- Narrow reads on banks 0 and 2 only (req=4'b0101) → gnt=4'b0101, bank_en_o=4'b0101, sel=0. narrow_rvalid_o=4'b0101 exactly BankLatency cycles later.
- Wide read with no narrow traffic → wide_gnt_o=1 the same cycle, bank_en_o=4'b1111, sel=1. wide_rvalid_o=1 after BankLatency cycles.
- MaxWideStall=4, narrow req=4'b0001 held continuously plus wide held → wide blocked 4 cycles, granted on the 5th with narrow_gnt=0. Narrow is granted again the next cycle, then the pattern repeats every 5 cycles.
- Wide request withdrawn while in WIDE_PRIO → state returns to NARROW_PRIO and the counter reads 0. The next narrow request is granted immediately.
- Mixed writes and reads: a wide write followed by a narrow read on bank 3 → only narrow_rvalid_o[3] pulses, at BankLatency after its grant.
